// File: rtl/reg_bus_sequencer.sv
// Control sequencer for the 8-bit register bank.
// Decodes one instruction byte and drives load/save enables over ISSUE/WRITE.
module reg_bus_sequencer #(
  parameter int NREG       = 6,
  parameter int RESULT_REG = 3
) (
  input  logic            clk,
  input  logic            res,
  input  logic            instr_valid,
  input  logic [7:0]      instr_byte,
  output logic            instr_ready,
  output logic [NREG-1:0] load1_en,
  output logic [NREG-1:0] load2_en,
  output logic [NREG-1:0] save_en,
  output logic [7:0]      imm_byte,
  output logic            imm_oe,
  output logic            alu_strobe,
  output logic            illegal,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WRITE, HALT
  } state_t;

  localparam logic [1:0] OP_COPY = 2'd0;
  localparam logic [1:0] OP_CALC = 2'd1;
  localparam logic [1:0] OP_IMM  = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  localparam logic [3:0] NREG_W  = 4'(NREG);
  localparam logic [2:0] RES_IDX = 3'(RESULT_REG);

  function automatic logic [NREG-1:0] onehot(
    input logic [2:0] idx
  );
    onehot = NREG'(1) << idx;
  endfunction

  state_t state, state_d;

  logic [1:0] op_q, op_n;
  logic [2:0] src_q, src_n;
  logic [2:0] dst_q, dst_n;
  logic [5:0] imm_q, imm_n;

  logic [1:0] in_op;
  logic [2:0] in_src, in_dst;
  logic       accept, bad;

  logic [NREG-1:0] l1_d, l2_d, sv_d;
  logic [7:0]      imm_d;
  logic            oe_d, alu_d;
  logic            ill_d, hlt_d, rdy_d;

  assign in_op  = instr_byte[7:6];
  assign in_src = instr_byte[5:3];
  assign in_dst = instr_byte[2:0];
  assign accept = instr_valid & instr_ready;

  // Only COPY/CALC carry register indices that can be out of range
  assign bad = ~in_op[1] &
               (({1'b0, in_src} >= NREG_W) |
                ({1'b0, in_dst} >= NREG_W));

  assign op_n  = accept ? in_op : op_q;
  assign src_n = accept ? in_src : src_q;
  assign dst_n = accept ? in_dst : dst_q;
  assign imm_n = accept ? instr_byte[5:0] : imm_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      op_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q  <= in_op;
        src_q <= in_src;
        dst_q <= in_dst;
        imm_q <= instr_byte[5:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            in_op == OP_HALT: state_d = HALT;
            in_op == OP_IMM:  state_d = WRITE;
            bad:              state_d = IDLE;
            default:          state_d = ISSUE;
          endcase
        end
      end
      ISSUE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state, then registered
  always_comb begin
    l1_d  = '0;
    l2_d  = '0;
    sv_d  = '0;
    imm_d = imm_byte;
    oe_d  = 1'b0;
    alu_d = 1'b0;
    ill_d = accept & bad;
    hlt_d = (state_d == HALT);
    rdy_d = (state_d == IDLE);
    unique case (state_d)
      ISSUE: begin
        l1_d = onehot(src_n);
        if (op_n == OP_CALC)
          l2_d = onehot(dst_n);
      end
      WRITE: begin
        unique case (op_n)
          OP_COPY: begin
            l1_d = onehot(src_n);
            sv_d = onehot(dst_n);
          end
          OP_CALC: begin
            l1_d  = onehot(src_n);
            l2_d  = onehot(dst_n);
            sv_d  = onehot(RES_IDX);
            alu_d = 1'b1;
          end
          OP_IMM: begin
            oe_d  = 1'b1;
            imm_d = {2'b00, imm_n};
            sv_d  = onehot(3'd0);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      instr_ready <= 1'b1;
      load1_en    <= '0;
      load2_en    <= '0;
      save_en     <= '0;
      imm_byte    <= '0;
      imm_oe      <= 1'b0;
      alu_strobe  <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_ready <= rdy_d;
      load1_en    <= l1_d;
      load2_en    <= l2_d;
      save_en     <= sv_d;
      imm_byte    <= imm_d;
      imm_oe      <= oe_d;
      alu_strobe  <= alu_d;
      illegal     <= ill_d;
      halted      <= hlt_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer.
// Stimulus pushes predicted per-cycle outputs; a monitor pops and compares.
module tb_reg_bus_sequencer;

  localparam int NREG = 6;
  localparam int RR   = 3;

  logic            clk = 1'b0;
  logic            res;
  logic            instr_valid;
  logic [7:0]      instr_byte;
  logic            instr_ready;
  logic [NREG-1:0] load1_en;
  logic [NREG-1:0] load2_en;
  logic [NREG-1:0] save_en;
  logic [7:0]      imm_byte;
  logic            imm_oe;
  logic            alu_strobe;
  logic            illegal;
  logic            halted;

  reg_bus_sequencer #(
    .NREG(NREG),
    .RESULT_REG(RR)
  ) dut (
    .clk(clk),
    .res(res),
    .instr_valid(instr_valid),
    .instr_byte(instr_byte),
    .instr_ready(instr_ready),
    .load1_en(load1_en),
    .load2_en(load2_en),
    .save_en(save_en),
    .imm_byte(imm_byte),
    .imm_oe(imm_oe),
    .alu_strobe(alu_strobe),
    .illegal(illegal),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            rdy;
    logic [NREG-1:0] l1;
    logic [NREG-1:0] l2;
    logic [NREG-1:0] sv;
    logic [7:0]      imm;
    logic            oe;
    logic            alu;
    logic            ill;
    logic            hlt;
  } snap_t;

  snap_t exp_q[$];
  snap_t pend[$];
  snap_t cur = '0;
  logic [7:0] imm_last = '0;
  bit halted_m = 1'b0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  function automatic logic [NREG-1:0] bitof(input int i);
    return NREG'(1 << i);
  endfunction

  function automatic snap_t base();
    snap_t s;
    s = '0;
    s.imm = imm_last;
    return s;
  endfunction

  // Transaction-level prediction of the cycle after this edge
  task automatic model_edge(input bit r, input bit v,
                            input logic [7:0] b);
    snap_t s, w;
    int op, sr, ds;
    op = int'(b[7:6]);
    sr = int'(b[5:3]);
    ds = int'(b[2:0]);
    if (r) begin
      imm_last = '0;
      pend.delete();
      halted_m = 1'b0;
      s = base();
      s.rdy = 1'b1;
    end else if (pend.size() > 0) begin
      s = pend.pop_front();
    end else if (cur.rdy && v) begin
      s = base();
      if (op == 3) begin
        halted_m = 1'b1;
        s.hlt = 1'b1;
      end else if (op == 2) begin
        imm_last = {2'b00, b[5:0]};
        s = base();
        s.oe = 1'b1;
        s.sv = bitof(0);
      end else if (sr >= NREG || ds >= NREG) begin
        s.ill = 1'b1;
        s.rdy = 1'b1;
      end else begin
        s.l1 = bitof(sr);
        if (op == 1) s.l2 = bitof(ds);
        w = s;
        if (op == 1) begin
          w.sv  = bitof(RR);
          w.alu = 1'b1;
        end else begin
          w.sv = bitof(ds);
        end
        pend.push_back(w);
      end
    end else if (halted_m) begin
      s = base();
      s.hlt = 1'b1;
    end else begin
      s = base();
      s.rdy = 1'b1;
    end
    cur = s;
    exp_q.push_back(s);
  endtask

  task automatic step(input bit r, input bit v,
                      input logic [7:0] b);
    res = r;
    instr_valid = v;
    instr_byte = b;
    @(posedge clk);
    model_edge(r, v, b);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin : mon
    snap_t a, e;
    forever begin
      @(negedge clk);
      if (!done) begin
        a = {instr_ready, load1_en, load2_en, save_en,
             imm_byte, imm_oe, alu_strobe, illegal, halted};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL no_expectation t=%0t got %h", $time, a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got %h want %h",
                     $time, a, e);
          end
        end
        checks++;
        if ($countones(a.sv) > 1 || $countones(a.l1) > 1 ||
            $countones(a.l2) > 1 || (a.oe && a.l1 != '0) ||
            ((a.rdy || a.hlt) && a.sv != '0)) begin
          errors++;
          $display("FAIL invariant t=%0t got %h want legal enables",
                   $time, a);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    bit r, v;
    res = 1'b1;
    instr_valid = 1'b0;
    instr_byte = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(1);
    // reset held mid-CALC
    step(1'b0, 1'b1, 8'b01_001_100);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(2);
    step(1'b0, 1'b1, 8'b00_010_101);
    idle(3);
    step(1'b0, 1'b1, 8'b01_001_100);
    idle(3);
    step(1'b0, 1'b1, 8'b10_101010);
    idle(2);
    step(1'b0, 1'b1, 8'b00_111_000);
    step(1'b0, 1'b1, 8'b00_001_010);
    idle(3);
    step(1'b0, 1'b1, 8'b01_110_001);
    step(1'b0, 1'b1, 8'b01_101_101);
    step(1'b0, 1'b1, 8'b00_011_011);
    idle(3);
    // back-to-back offers, byte changing mid-sequence
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 8'(i * 9));
    idle(3);
    step(1'b0, 1'b1, 8'hC0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 8'b00_100_001);
    step(1'b1, 1'b1, 8'b00_100_001);
    step(1'b0, 1'b1, 8'b00_100_001);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0) ||
          (halted_m && $urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      if (b[7:6] == 2'b11 && $urandom_range(0, 3) != 0)
        b[7:6] = 2'($urandom_range(0, 2));
      step(r, v, b);
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
